// File: rtl/fib_gen.sv
// rtl/fib_gen.sv - iterative Fibonacci-type sequence generator with start/busy/done handshake
//
// Purpose:
//   Computes x(idx) of the recurrence x(n+1) = x(n) + x(n-1) from the seeds
//   x(0)=seed0 and x(1)=seed1. It performs one iteration per enabled clock.
//   The result is reported modulo 2^DW, with a flag when the true value
//   does not fit in DW bits.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ce       in   clock enable; when low, every register holds
//   start    in   request, accepted only in IDLE with ce=1
//   idx      in   [IW-1:0] requested index, sampled with start
//   seed0    in   [DW-1:0] x(0), sampled with start
//   seed1    in   [DW-1:0] x(1), sampled with start
//   busy     out  computation in progress
//   done     out  one-enabled-cycle pulse; fib_out/ovf were just updated
//   fib_out  out  [DW-1:0] x(idx) mod 2^DW, held until next completion
//   ovf      out  true x(idx) >= 2^DW, held alongside fib_out

module fib_gen #(
  parameter int DW = 16,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          start,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] seed0,
  input  logic [DW-1:0] seed1,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] fib_out,
  output logic          ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          a_ov_q, a_ov_d;
  logic          b_ov_q, b_ov_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] fib_q, fib_d;
  logic          ovf_q, ovf_d;

  // The extra top bit carries out of the DW-bit addition.
  logic [DW:0]   sum_w;

  assign sum_w = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ov_d  = a_ov_q;
    b_ov_d  = b_ov_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fib_d   = fib_q;
    ovf_d   = ovf_q;

    if (ce) begin
      // The done pulse lasts exactly one enabled cycle.
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = seed0;
            b_d     = seed1;
            a_ov_d  = 1'b0;
            b_ov_d  = 1'b0;
            cnt_d   = idx;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            a_d    = b_q;
            a_ov_d = b_ov_q;
            b_d    = sum_w[DW-1:0];
            // Overflow is sticky: once a term is wrong, every later term is too.
            b_ov_d = sum_w[DW] | a_ov_q | b_ov_q;
            cnt_d  = cnt_q - IW'(1);
          end else begin
            // Only a holds x(idx); b's overflow concerns x(idx+1) and is ignored.
            fib_d   = a_q;
            ovf_d   = a_ov_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ov_q  <= 1'b0;
      b_ov_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fib_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ov_q  <= a_ov_d;
      b_ov_q  <= b_ov_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fib_q   <= fib_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fib_out = fib_q;
  assign ovf     = ovf_q;

endmodule
